// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types, default widths and slice placement helper for mult_seq
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIX   = 2'd2
    } mult_state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_A_SLICE = 8;
    localparam int DEF_B_SLICE = 16;

    // Bit position of the partial product formed from a-slice i and b-slice j
    function automatic int slice_shift(input int i, input int j,
                                       input int a_slice = DEF_A_SLICE,
                                       input int b_slice = DEF_B_SLICE);
        return i * a_slice + j * b_slice;
    endfunction

endpackage

// File: rtl/mult_slice.sv
// rtl/mult_slice.sv - combinational unsigned narrow slice multiplier
module mult_slice #(
    parameter int A_W = 8,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    output logic [A_W+B_W-1:0] p_o
);

    assign p_o = (A_W + B_W)'(a_i) * (A_W + B_W)'(b_i);

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - multi-cycle sliced multiplier with signed mode and done pulse
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int A_SLICE = DEF_A_SLICE,
    parameter int B_SLICE = DEF_B_SLICE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int NA = WIDTH / A_SLICE;
    localparam int NB = WIDTH / B_SLICE;
    localparam int PW = 2 * WIDTH;
    localparam int SW = A_SLICE + B_SLICE;
    localparam int IW = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

    mult_state_t        state_q;
    logic [IW-1:0]      i_q;
    logic [JW-1:0]      j_q;
    logic [WIDTH-1:0]   amag_q, bmag_q;
    logic               neg_q;
    logic [PW-1:0]      product_q;
    logic               busy_q, done_q;

    logic [WIDTH-1:0]   amag_d, bmag_d;
    logic               neg_d;
    logic [A_SLICE-1:0] a_sl;
    logic [B_SLICE-1:0] b_sl;
    logic [SW-1:0]      pp;
    logic [PW-1:0]      pp_ext;
    logic [PW-1:0]      accum_d, fix_d;

    // Operand magnitudes and result sign; -2^(WIDTH-1) maps onto itself as an unsigned magnitude
    always_comb begin
        amag_d = (signed_mode && a[WIDTH-1]) ? -a : a;
        bmag_d = (signed_mode && b[WIDTH-1]) ? -b : b;
        neg_d  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    // Pick the current slices of the latched magnitudes
    always_comb begin
        a_sl = A_SLICE'(amag_q >> (int'(i_q) * A_SLICE));
        b_sl = B_SLICE'(bmag_q >> (int'(j_q) * B_SLICE));
    end

    mult_slice #(
        .A_W (A_SLICE),
        .B_W (B_SLICE)
    ) u_slice (
        .a_i (a_sl),
        .b_i (b_sl),
        .p_o (pp)
    );

    // Place the partial product, accumulate it, and form the sign-corrected result
    always_comb begin
        pp_ext  = PW'(pp) << slice_shift(int'(i_q), int'(j_q), A_SLICE, B_SLICE);
        accum_d = product_q + pp_ext;
        fix_d   = neg_q ? -product_q : product_q;
    end

    // Control FSM: accept, walk i (inner) then j (outer), then apply the sign
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            amag_q    <= '0;
            bmag_q    <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        amag_q    <= amag_d;
                        bmag_q    <= bmag_d;
                        neg_q     <= neg_d;
                        product_q <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    product_q <= accum_d;
                    if (i_q == I_LAST) begin
                        i_q <= '0;
                        if (j_q == J_LAST) begin
                            j_q     <= '0;
                            state_q <= FIX;
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                FIX: begin
                    product_q <= fix_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - randomized self-checking bench for mult_seq with a reference model
module tb_mult_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic        sm_v    [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [63:0] prod_v  [2];

    logic        busy0, done0, busy1, done1;
    logic [63:0] p0;
    logic [31:0] p1;

    mult_seq u0 (
        .clk         (clk),
        .reset       (reset),
        .start       (start_v[0]),
        .signed_mode (sm_v[0]),
        .a           (a_v[0]),
        .b           (b_v[0]),
        .busy        (busy0),
        .done        (done0),
        .product     (p0)
    );

    mult_seq #(.WIDTH(16), .A_SLICE(4), .B_SLICE(8)) u1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start_v[1]),
        .signed_mode (sm_v[1]),
        .a           (a_v[1][15:0]),
        .b           (b_v[1][15:0]),
        .busy        (busy1),
        .done        (done1),
        .product     (p1)
    );

    always_comb begin
        busy_v[0] = busy0;
        done_v[0] = done0;
        prod_v[0] = p0;
        busy_v[1] = busy1;
        done_v[1] = done1;
        prod_v[1] = {32'b0, p1};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int wof(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    // Mathematical product of two w-bit operands, reduced to 2w bits
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm, input int w);
        longint av, bv;
        logic [63:0] p;
        av = longint'({32'b0, a}) & ((longint'(1) << w) - 1);
        bv = longint'({32'b0, b}) & ((longint'(1) << w) - 1);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        p = 64'(av * bv);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    // Reference model: an accepted start yields done N+1 edges later; product is defined only when idle
    localparam int N = 8;
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_pv   [2];
    int          m_cnt  [2];
    logic [63:0] m_prod [2];
    logic [63:0] m_exp  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 0; m_done[k] = 0; m_pv[k] = 1; m_cnt[k] = 0; m_prod[k] = '0;
            end else begin
                m_done[k] = 0;
                if (m_busy[k]) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_busy[k] = 0; m_done[k] = 1; m_prod[k] = m_exp[k]; m_pv[k] = 1;
                    end
                end else if (start_v[k]) begin
                    m_busy[k] = 1;
                    m_cnt[k]  = N + 1;
                    m_exp[k]  = ref_mul(a_v[k], b_v[k], sm_v[k], wof(k));
                    m_pv[k]   = 0;
                end
            end
        end
    end

    bit cmp_en = 0;
    always begin
        @(posedge clk);
        #1;
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("busy[%0d]", k), 64'(busy_v[k]), 64'(m_busy[k]));
                chk($sformatf("done[%0d]", k), 64'(done_v[k]), 64'(m_done[k]));
                if (m_pv[k]) chk($sformatf("product[%0d]", k), prod_v[k], m_prod[k]);
            end
        end
    end

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic sm, input logic [63:0] exp, input string name);
        int n;
        @(negedge clk);
        start_v[k] = 1; a_v[k] = a; b_v[k] = b; sm_v[k] = sm;
        @(negedge clk);
        start_v[k] = 0; a_v[k] = $urandom; b_v[k] = $urandom; sm_v[k] = 1'($urandom);
        n = 1;
        while (!done_v[k] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 64'(n - 1), 64'd9);
        chk({name, " product"}, prod_v[k], exp);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dn, first, second, cnt;
        logic [63:0] got;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 0; sm_v[k] = 0; a_v[k] = '0; b_v[k] = '0;
        end
        cmp_en = 1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset product", p0, 64'd0);
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || done1) dn++;
        end
        chk("idle no done", 64'(dn), 64'd0);

        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u max");
        run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, "u mix");
        run_op(0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s neg");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s min");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u min");
        run_op(1, 32'h0000_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0000_0001_FFFE, "w16 u");
        run_op(1, 32'h0000_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0000_FFFF_FFFE, "w16 s");

        // Start pulse while busy is ignored
        @(negedge clk);
        start_v[0] = 1; a_v[0] = 32'h1234_5678; b_v[0] = 32'h9ABC_DEF0; sm_v[0] = 0;
        dn = 0; got = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start_v[0] = (c == 3);
            if (c == 3) begin a_v[0] = 32'd1; b_v[0] = 32'd1; end
            if (done0) begin dn++; got = p0; end
        end
        chk("ignored start done count", 64'(dn), 64'd1);
        chk("ignored start product", got, 64'h0B00_EA4E_242D_2080);

        // Start held high: back-to-back operations
        @(negedge clk);
        start_v[0] = 1; a_v[0] = 32'd7; b_v[0] = 32'd9; sm_v[0] = 0;
        first = 0; second = 0; cnt = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done0) begin
                cnt++;
                if (cnt == 1) first = n;
                if (cnt == 2) second = n;
                chk("held product", p0, 64'd63);
            end
        end
        start_v[0] = 0;
        chk("held first done", 64'(first), 64'd10);
        chk("held period", 64'(second - first), 64'd10);
        chk("held done count", 64'(cnt), 64'd4);
        repeat (15) @(negedge clk);

        // Reset during the fourth accumulation cycle
        @(negedge clk);
        start_v[0] = 1; a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'hFFFF_FFFF; sm_v[0] = 0;
        @(negedge clk);
        start_v[0] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid reset busy", 64'(busy0), 64'd0);
        chk("mid reset done", 64'(done0), 64'd0);
        chk("mid reset product", p0, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 32'd5, 32'd6, 1'b0, 64'd30, "after reset");

        // Randomized traffic on both instances, with occasional resets
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < 2; k++) begin
                start_v[k] = ($urandom_range(0, 3) == 0);
                a_v[k]     = pick();
                b_v[k]     = pick();
                sm_v[k]    = 1'($urandom);
            end
        end
        reset = 1'b0;
        start_v[0] = 0;
        start_v[1] = 0;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
